// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared AHB transfer/burst encodings, arbiter state encoding and default bus sizing.
package AhbGlobalPackage;

  localparam int unsigned NO_OF_MASTERS  = 2;
  localparam int unsigned HMASTER_WIDTH  = (NO_OF_MASTERS == 1) ? 1 : $clog2(NO_OF_MASTERS);
  localparam int unsigned BEAT_CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } ahbTransferEnum;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } ahbBurstEnum;

  typedef enum logic [1:0] {
    ARB    = 2'b00,
    BURST  = 2'b01,
    LOCKED = 2'b10
  } arbStateEnum;

  // SEQ beats still owed after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
  function automatic logic [BEAT_CNT_WIDTH-1:0] burst_beats_left(input logic [2:0] burst);
    case (burst)
      WRAP4,  INCR4:  burst_beats_left = BEAT_CNT_WIDTH'(3);
      WRAP8,  INCR8:  burst_beats_left = BEAT_CNT_WIDTH'(7);
      WRAP16, INCR16: burst_beats_left = BEAT_CNT_WIDTH'(15);
      default:        burst_beats_left = '0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_round_robin_picker.sv
// Combinational round-robin pick: first requester strictly after last_owner, parking on master 0.
module ahb_round_robin_picker #(
  parameter int unsigned NO_OF_MASTERS = 2,
  parameter int unsigned HMASTER_WIDTH = 1
) (
  input  logic [NO_OF_MASTERS-1:0] req,
  input  logic [HMASTER_WIDTH-1:0] last_owner,
  output logic [NO_OF_MASTERS-1:0] grant_c
);

  always_comb begin
    int unsigned idx;
    logic        found;
    idx     = 0;
    found   = 1'b0;
    grant_c = '0;
    for (int unsigned i = 1; i <= NO_OF_MASTERS; i++) begin
      idx = (32'(last_owner) + i) % NO_OF_MASTERS;
      if (!found && req[HMASTER_WIDTH'(idx)]) begin
        grant_c[HMASTER_WIDTH'(idx)] = 1'b1;
        found                        = 1'b1;
      end
    end
    if (!found) grant_c[0] = 1'b1;
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: round-robin grant, held for fixed-length bursts and locked sequences.
module ahb_bus_arbiter #(
  parameter int unsigned NO_OF_MASTERS = AhbGlobalPackage::NO_OF_MASTERS,
  parameter int unsigned HMASTER_WIDTH = (NO_OF_MASTERS == 1) ? 1 : $clog2(NO_OF_MASTERS)
) (
  input  logic                     hclk,
  input  logic                     hreset,
  input  logic [NO_OF_MASTERS-1:0] hbusreq,
  input  logic [NO_OF_MASTERS-1:0] hlock,
  input  logic [1:0]               htrans,
  input  logic [2:0]               hburst,
  input  logic                     hready,
  output logic [NO_OF_MASTERS-1:0] hgrant,
  output logic [HMASTER_WIDTH-1:0] hmaster,
  output logic                     hmastlock
);

  import AhbGlobalPackage::arbStateEnum;
  import AhbGlobalPackage::ARB;
  import AhbGlobalPackage::BURST;
  import AhbGlobalPackage::LOCKED;
  import AhbGlobalPackage::IDLE;
  import AhbGlobalPackage::NONSEQ;
  import AhbGlobalPackage::SEQ;
  import AhbGlobalPackage::BEAT_CNT_WIDTH;
  import AhbGlobalPackage::burst_beats_left;

  arbStateEnum               state, state_next;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt, cnt_next;
  logic [HMASTER_WIDTH-1:0]  last_owner, grant_idx, pick_idx;
  logic [NO_OF_MASTERS-1:0]  pick_grant;

  function automatic logic [HMASTER_WIDTH-1:0] onehot_idx(input logic [NO_OF_MASTERS-1:0] oh);
    onehot_idx = '0;
    for (int unsigned i = 0; i < NO_OF_MASTERS; i++)
      if (oh[HMASTER_WIDTH'(i)]) onehot_idx = HMASTER_WIDTH'(i);
  endfunction

  ahb_round_robin_picker #(
    .NO_OF_MASTERS (NO_OF_MASTERS),
    .HMASTER_WIDTH (HMASTER_WIDTH)
  ) u_picker (
    .req        (hbusreq),
    .last_owner (last_owner),
    .grant_c    (pick_grant)
  );

  assign grant_idx = onehot_idx(hgrant);
  assign pick_idx  = onehot_idx(pick_grant);

  // Beats remaining in the owner's fixed burst after this cycle's transfer.
  always_comb begin
    cnt_next = beat_cnt;
    if (hready) begin
      case (htrans)
        NONSEQ:  cnt_next = burst_beats_left(hburst);
        SEQ:     if (beat_cnt != '0) cnt_next = beat_cnt - BEAT_CNT_WIDTH'(1);
        IDLE:    cnt_next = '0;
        default: cnt_next = beat_cnt;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB: begin
        if (hready) begin
          if (hlock[grant_idx])       state_next = LOCKED;
          else if (cnt_next != '0)    state_next = BURST;
        end
      end
      BURST: begin
        if (hready && cnt_next == '0) state_next = ARB;
      end
      LOCKED: begin
        // Release only once the owner has dropped hlock and a transfer completes.
        if (hready && !hlock[hmaster])
          state_next = (cnt_next != '0) ? BURST : ARB;
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) state <= ARB;
    else        state <= state_next;
  end

  // Grant reopens on any edge that lands in ARB, so a finishing burst hands over immediately.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      hgrant     <= NO_OF_MASTERS'(1);
      hmaster    <= '0;
      hmastlock  <= 1'b0;
      beat_cnt   <= '0;
      last_owner <= '0;
    end else begin
      beat_cnt <= cnt_next;
      if (state_next == ARB) begin
        hgrant     <= pick_grant;
        last_owner <= pick_idx;
      end
      if (hready) begin
        hmaster   <= grant_idx;
        hmastlock <= hlock[grant_idx];
      end
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: reset, round-robin, bursts, wait states, lock and early termination.
module tb_ahb_bus_arbiter;
  import AhbGlobalPackage::*;

  localparam int unsigned NM = 2;
  localparam int unsigned HW = 1;

  logic          hclk = 1'b0;
  logic          hreset;
  logic [NM-1:0] hbusreq;
  logic [NM-1:0] hlock;
  logic [1:0]    htrans;
  logic [2:0]    hburst;
  logic          hready;
  logic [NM-1:0] hgrant;
  logic [HW-1:0] hmaster;
  logic          hmastlock;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 hclk = ~hclk;

  ahb_bus_arbiter #(
    .NO_OF_MASTERS (NM),
    .HMASTER_WIDTH (HW)
  ) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge hclk);
    #1;
    check("hgrant_onehot", 32'($onehot(hgrant)), 32'd1);
  endtask

  task automatic drv(input logic [1:0] req, input logic [1:0] lk, input logic [1:0] tr,
                     input logic [2:0] bu, input logic rdy);
    hbusreq = req;
    hlock   = lk;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
  endtask

  task automatic chk_bus(input string tag, input logic [1:0] g, input logic m, input logic ml);
    check({tag, "/hgrant"},    32'(hgrant),    32'(g));
    check({tag, "/hmaster"},   32'(hmaster),   32'(m));
    check({tag, "/hmastlock"}, 32'(hmastlock), 32'(ml));
  endtask

  task automatic chk_st(input string tag, input arbStateEnum st, input logic [3:0] c);
    check({tag, "/state"}, 32'(dut.state),    32'(st));
    check({tag, "/count"}, 32'(dut.beat_cnt), 32'(c));
  endtask

  initial begin
    // reset with both masters requesting
    hreset = 1'b1;
    drv(2'b11, 2'b00, IDLE, SINGLE, 1'b1);
    cyc(); cyc();
    chk_bus("reset", 2'b01, 1'b0, 1'b0);
    chk_st("reset", ARB, 4'd0);
    hreset = 1'b0;

    // round robin with SINGLE transfers
    drv(2'b11, 2'b00, NONSEQ, SINGLE, 1'b1);
    cyc(); chk_bus("rr1", 2'b10, 1'b0, 1'b0);
    cyc(); chk_bus("rr2", 2'b01, 1'b1, 1'b0);
    cyc(); chk_bus("rr3", 2'b10, 1'b0, 1'b0);

    // INCR4 by m0 while m1 requests
    drv(2'b01, 2'b00, IDLE, SINGLE, 1'b1);
    cyc(); cyc(); chk_bus("incr4_setup", 2'b01, 1'b0, 1'b0);
    drv(2'b11, 2'b00, NONSEQ, INCR4, 1'b1);
    cyc(); chk_st("incr4_nonseq", BURST, 4'd3); check("incr4_nonseq/hgrant", 32'(hgrant), 32'h1);
    drv(2'b11, 2'b00, SEQ, INCR4, 1'b1);
    cyc(); chk_st("incr4_seq1", BURST, 4'd2); check("incr4_seq1/hgrant", 32'(hgrant), 32'h1);
    cyc(); chk_st("incr4_seq2", BURST, 4'd1); check("incr4_seq2/hgrant", 32'(hgrant), 32'h1);
    cyc(); chk_st("incr4_seq3", ARB, 4'd0);   check("incr4_seq3/hgrant", 32'(hgrant), 32'h2);

    // INCR8 by m0 with three wait states
    drv(2'b01, 2'b00, IDLE, SINGLE, 1'b1);
    cyc(); cyc(); chk_bus("incr8_setup", 2'b01, 1'b0, 1'b0);
    drv(2'b11, 2'b00, NONSEQ, INCR8, 1'b1);
    cyc(); chk_st("incr8_nonseq", BURST, 4'd7);
    drv(2'b11, 2'b00, SEQ, INCR8, 1'b1);
    cyc(); cyc(); chk_st("incr8_seq2", BURST, 4'd5);
    drv(2'b11, 2'b00, SEQ, INCR8, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(); chk_st("incr8_wait", BURST, 4'd5); chk_bus("incr8_wait", 2'b01, 1'b0, 1'b0);
    end
    drv(2'b11, 2'b00, SEQ, INCR8, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc(); chk_st("incr8_tail", BURST, 4'(4 - k)); check("incr8_tail/hgrant", 32'(hgrant), 32'h1);
    end
    cyc(); chk_st("incr8_last", ARB, 4'd0); check("incr8_last/hgrant", 32'(hgrant), 32'h2);

    // INCR16 by m0 terminated early with IDLE
    drv(2'b01, 2'b00, IDLE, SINGLE, 1'b1);
    cyc(); cyc(); chk_bus("incr16_setup", 2'b01, 1'b0, 1'b0);
    drv(2'b11, 2'b00, NONSEQ, INCR16, 1'b1);
    cyc(); chk_st("incr16_nonseq", BURST, 4'd15);
    drv(2'b11, 2'b00, SEQ, INCR16, 1'b1);
    cyc(); chk_st("incr16_seq", BURST, 4'd14); check("incr16_seq/hgrant", 32'(hgrant), 32'h1);
    drv(2'b11, 2'b00, IDLE, INCR16, 1'b1);
    cyc(); chk_st("incr16_idle", ARB, 4'd0); check("incr16_idle/hgrant", 32'(hgrant), 32'h2);

    // m1 locked across two INCR4 bursts while m0 requests
    drv(2'b11, 2'b10, IDLE, SINGLE, 1'b1);
    cyc(); chk_st("lock_take", LOCKED, 4'd0); chk_bus("lock_take", 2'b10, 1'b1, 1'b1);
    for (int b = 0; b < 2; b++) begin
      drv(2'b11, 2'b10, NONSEQ, INCR4, 1'b1);
      cyc(); chk_st("lock_nonseq", LOCKED, 4'd3);
      drv(2'b11, 2'b10, SEQ, INCR4, 1'b1);
      cyc(); cyc(); cyc();
      chk_st("lock_burst_end", LOCKED, 4'd0); chk_bus("lock_burst_end", 2'b10, 1'b1, 1'b1);
    end
    drv(2'b11, 2'b00, IDLE, SINGLE, 1'b0);
    cyc(); chk_st("unlock_wait", LOCKED, 4'd0); chk_bus("unlock_wait", 2'b10, 1'b1, 1'b1);
    drv(2'b11, 2'b00, IDLE, SINGLE, 1'b1);
    cyc(); chk_st("unlock", ARB, 4'd0); chk_bus("unlock", 2'b01, 1'b1, 1'b0);

    // lock released mid INCR4 falls back to BURST
    drv(2'b10, 2'b10, IDLE, SINGLE, 1'b1);
    cyc(); chk_st("lk2_grant", ARB, 4'd0); chk_bus("lk2_grant", 2'b10, 1'b0, 1'b0);
    cyc(); chk_st("lk2_take", LOCKED, 4'd0); chk_bus("lk2_take", 2'b10, 1'b1, 1'b1);
    drv(2'b10, 2'b10, NONSEQ, INCR4, 1'b1);
    cyc(); chk_st("lk2_nonseq", LOCKED, 4'd3);
    drv(2'b11, 2'b00, SEQ, INCR4, 1'b1);
    cyc(); chk_st("lk2_release", BURST, 4'd2); chk_bus("lk2_release", 2'b10, 1'b1, 1'b0);
    cyc(); chk_st("lk2_seq2", BURST, 4'd1); check("lk2_seq2/hgrant", 32'(hgrant), 32'h2);
    cyc(); chk_st("lk2_seq3", ARB, 4'd0);   check("lk2_seq3/hgrant", 32'(hgrant), 32'h1);

    // reset in the middle of a locked burst
    drv(2'b10, 2'b10, IDLE, SINGLE, 1'b1);
    cyc(); check("rstlk_grant/hgrant", 32'(hgrant), 32'h2);
    cyc(); chk_st("rstlk_take", LOCKED, 4'd0); chk_bus("rstlk_take", 2'b10, 1'b1, 1'b1);
    drv(2'b10, 2'b10, NONSEQ, INCR4, 1'b1);
    cyc(); chk_st("rstlk_nonseq", LOCKED, 4'd3);
    hreset = 1'b1;
    drv(2'b10, 2'b10, SEQ, INCR4, 1'b1);
    cyc(); chk_st("rstlk_reset", ARB, 4'd0); chk_bus("rstlk_reset", 2'b01, 1'b0, 1'b0);
    hreset = 1'b0;

    // grant to m1, then park on m0 with no requests
    drv(2'b10, 2'b00, IDLE, SINGLE, 1'b1);
    cyc(); check("park_pre/hgrant", 32'(hgrant), 32'h2);
    drv(2'b00, 2'b00, IDLE, SINGLE, 1'b1);
    cyc(); check("park/hgrant", 32'(hgrant), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
